// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer that drives one registered fulladder, LSB first, 3 cycles per bit.
// Optional build macro SERIAL_ADD_CG_EN: the adder clock enable comes from a falling-edge flop on busy.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  output logic             fa_cg_en,
  output logic             fa_scan_en,
  input  logic             fa_sum,
  input  logic             fa_carry
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [BW-1:0]    bit_idx;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] acc;

  // Right-shift a word and insert a new bit at the MSB; after WIDTH shifts bit i lands at [i].
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] word, input logic msb);
    logic [WIDTH-1:0] w;
    w = word >> 1;
    w[WIDTH-1] = msb;
    return w;
  endfunction

  assign fa_scan_en = 1'b0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      phase   <= 2'd0;
      bit_idx <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      fa_a    <= 1'b0;
      fa_b    <= 1'b0;
      fa_c    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a    <= op_a >> 1;
            sh_b    <= op_b >> 1;
            fa_a    <= op_a[0];
            fa_b    <= op_b[0];
            fa_c    <= cin;
            phase   <= 2'd0;
            bit_idx <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (phase != 2'd2) begin
            phase <= phase + 2'd1;
          end else begin
            // Adder outputs are valid only here; the input flops and output flops each took one edge.
            phase <= 2'd0;
            acc   <= shift_in(acc, fa_sum);
            if (bit_idx == LAST) begin
              result <= shift_in(acc, fa_sum);
              cout   <= fa_carry;
              busy   <= 1'b0;
              done   <= 1'b1;
              state  <= IDLE;
            end else begin
              fa_a    <= sh_a[0];
              fa_b    <= sh_b[0];
              fa_c    <= fa_carry;
              sh_a    <= sh_a >> 1;
              sh_b    <= sh_b >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_ADD_CG_EN
  // Enable changes only while Clock is low, so Clock & fa_cg_en cannot glitch.
  always_ff @(negedge Clock or posedge Reset) begin
    if (Reset) fa_cg_en <= 1'b0;
    else       fa_cg_en <= busy;
  end
`else
  assign fa_cg_en = 1'b1;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, each with a registered fulladder model.
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

`ifdef SERIAL_ADD_CG_EN
  localparam logic CG_IDLE = 1'b0;
  localparam int IDLE_EDGES = 0;
`else
  localparam logic CG_IDLE = 1'b1;
  localparam int IDLE_EDGES = 5;
`endif

  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, result8;
  logic       fa_a8, fa_b8, fa_c8, cg8, scan8, sum8, carry8;
  logic       start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, result1;
  logic       fa_a1, fa_b1, fa_c1, cg1, scan1, sum1, carry1;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .Clock(clk), .Reset(rst), .start(start8), .op_a(a8), .op_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_c(fa_c8), .fa_cg_en(cg8), .fa_scan_en(scan8),
    .fa_sum(sum8), .fa_carry(carry8)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .Clock(clk), .Reset(rst), .start(start1), .op_a(a1), .op_b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_c(fa_c1), .fa_cg_en(cg1), .fa_scan_en(scan1),
    .fa_sum(sum1), .fa_carry(carry1)
  );

  // Registered fulladder models: input flops, then output flops, both on the gated clock, no reset.
  logic ia8, ib8, ic8, ia1, ib1, ic1;
  always @(posedge clk) begin
    if (cg8 === 1'b1) begin
      ia8 <= fa_a8; ib8 <= fa_b8; ic8 <= fa_c8;
      {carry8, sum8} <= 2'(ia8) + 2'(ib8) + 2'(ic8);
    end
    if (cg1 === 1'b1) begin
      ia1 <= fa_a1; ib1 <= fa_b1; ic1 <= fa_c1;
      {carry1, sum1} <= 2'(ia1) + 2'(ib1) + 2'(ic1);
    end
  end

  // Gated-edge counters and enable-change-while-high monitors.
  logic gclk8, gclk1;
  assign gclk8 = clk & cg8;
  assign gclk1 = clk & cg1;
  int gedges8 = 0;
  int gedges1 = 0;
  int glitch8 = 0;
  int glitch1 = 0;
  always @(posedge gclk8) gedges8 <= gedges8 + 1;
  always @(posedge gclk1) gedges1 <= gedges1 + 1;
  always @(cg8) if (clk === 1'b1) glitch8 <= glitch8 + 1;
  always @(cg1) if (clk === 1'b1) glitch1 <= glitch1 + 1;

  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Drives one operation on the chosen instance and reports what it observed.
  task automatic run(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] res, output logic co, output int lat, output int edges);
    int e0;
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!(w1 ? busy1 : busy8)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL idle_wait busy=1 after 200 cycles, required 0");
    end
    if (w1) begin start1 = 1'b1; a1 = a[0]; b1 = b[0]; cin1 = c; end
    else    begin start8 = 1'b1; a8 = a;    b8 = b;    cin8 = c; end
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    start8 = 1'b0;
    e0 = w1 ? gedges1 : gedges8;
    lat = -1; res = '0; co = 1'b0; edges = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (w1 ? done1 : done8) begin
        lat   = k;
        res   = w1 ? {7'd0, result1} : result8;
        co    = w1 ? cout1 : cout8;
        edges = (w1 ? gedges1 : gedges8) - e0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", done8); end
    checks++; if (result8 !== 8'h00) begin failures++; $display("FAIL rst_result got %h want 00", result8); end
    checks++; if (cout8 !== 1'b0) begin failures++; $display("FAIL rst_cout got %b want 0", cout8); end
    checks++;
    if ({fa_a8, fa_b8, fa_c8} !== 3'b000) begin
      failures++; $display("FAIL rst_fa_abc got %b want 000", {fa_a8, fa_b8, fa_c8});
    end
    checks++; if (scan8 !== 1'b0) begin failures++; $display("FAIL rst_scan got %b want 0", scan8); end
    checks++; if (cg8 !== CG_IDLE) begin failures++; $display("FAIL rst_cg got %b want %b", cg8, CG_IDLE); end
    checks++; if (busy1 !== 1'b0) begin failures++; $display("FAIL rst_busy1 got %b want 0", busy1); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] res; logic co; int lat, edges;
    run(1'b0, 8'h5A, 8'h3C, 1'b0, res, co, lat, edges);
    checks++; if (res !== 8'h96) begin failures++; $display("FAIL d1_result got %h want 96", res); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL d1_cout got %b want 0", co); end
    checks++; if (lat !== 24) begin failures++; $display("FAIL d1_latency got %0d want 24", lat); end
    checks++; if (edges !== 24) begin failures++; $display("FAIL d1_gated_edges got %0d want 24", edges); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL d1_done_width got %b want 0", done8); end
    run(1'b0, 8'hFF, 8'h01, 1'b0, res, co, lat, edges);
    checks++; if (res !== 8'h00) begin failures++; $display("FAIL d2_result got %h want 00", res); end
    checks++; if (co !== 1'b1) begin failures++; $display("FAIL d2_cout got %b want 1", co); end
    run(1'b0, 8'h00, 8'h00, 1'b1, res, co, lat, edges);
    checks++; if (res !== 8'h01) begin failures++; $display("FAIL d3_result got %h want 01", res); end
    checks++; if (co !== 1'b0) begin failures++; $display("FAIL d3_cout got %b want 0", co); end
  endtask

  task automatic test_random();
    logic [7:0] a, b, res; logic c, co; logic [8:0] exp; int lat, edges;
    for (int n = 0; n < 12; n++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      exp = ref_add8(a, b, c);
      run(1'b0, a, b, c, res, co, lat, edges);
      checks++;
      if ({co, res} !== exp || lat !== 24) begin
        failures++;
        $display("FAIL rand%0d %h+%h+%b got cout=%b res=%h lat=%0d want cout=%b res=%h lat=24",
                 n, a, b, c, co, res, lat, exp[8], exp[7:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra [60];
    logic [7:0] rb [60];
    logic       rc [60];
    int pe [2];
    logic [8:0] got [2];
    logic [8:0] exp0, exp1;
    int pulses, second;
    bit ok;
    for (int i = 0; i < 60; i++) begin
      ra[i] = 8'($urandom); rb[i] = 8'($urandom); rc[i] = 1'($urandom);
    end
    pe[0] = -1; pe[1] = -1; got[0] = '0; got[1] = '0;
    pulses = 0;
    second = 3 * 8 + 1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!busy8) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin failures++; $display("FAIL b2b_idle busy=1, want 0"); end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done8) begin
        if (pulses < 2) begin pe[pulses] = i - 1; got[pulses] = {cout8, result8}; end
        pulses++;
      end
      start8 = (i < 40); a8 = ra[i]; b8 = rb[i]; cin8 = rc[i];
      @(posedge clk);
    end
    @(negedge clk);
    start8 = 1'b0;
    exp0 = ref_add8(ra[0], rb[0], rc[0]);
    exp1 = ref_add8(ra[second], rb[second], rc[second]);
    checks++; if (pulses !== 2) begin failures++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
    checks++; if (pe[0] !== 24) begin failures++; $display("FAIL b2b_edge0 got %0d want 24", pe[0]); end
    checks++; if (pe[1] !== 49) begin failures++; $display("FAIL b2b_edge1 got %0d want 49", pe[1]); end
    checks++; if (got[0] !== exp0) begin failures++; $display("FAIL b2b_res0 got %h want %h", got[0], exp0); end
    checks++; if (got[1] !== exp1) begin failures++; $display("FAIL b2b_res1 got %h want %h", got[1], exp1); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] res; logic co; int lat, edges, ndone;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL mid_busy got %b want 1", busy8); end
    checks++; if (cg8 !== 1'b1) begin failures++; $display("FAIL mid_cg got %b want 1", cg8); end
    rst = 1'b1;
    #1;
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL mrst_busy got %b want 0", busy8); end
    checks++; if (result8 !== 8'h00) begin failures++; $display("FAIL mrst_result got %h want 00", result8); end
    checks++;
    if ({fa_a8, fa_b8, fa_c8, cout8} !== 4'b0000) begin
      failures++; $display("FAIL mrst_fa_cout got %b want 0000", {fa_a8, fa_b8, fa_c8, cout8});
    end
    checks++; if (cg8 !== CG_IDLE) begin failures++; $display("FAIL mrst_cg got %b want %b", cg8, CG_IDLE); end
    #1;
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8 || busy8) ndone++;
    end
    checks++; if (ndone !== 0) begin failures++; $display("FAIL mrst_no_done got %0d want 0", ndone); end
    run(1'b0, 8'h12, 8'h34, 1'b0, res, co, lat, edges);
    checks++;
    if ({co, res} !== 9'h046 || lat !== 24) begin
      failures++; $display("FAIL mrst_next got %b/%h lat=%0d want 0/46 lat=24", co, res, lat);
    end
  endtask

  task automatic test_clock_gate();
    int e8;
    @(negedge clk);
    e8 = gedges8;
    repeat (5) @(negedge clk);
    checks++;
    if (gedges8 - e8 !== IDLE_EDGES) begin
      failures++; $display("FAIL cg_idle_edges got %0d want %0d", gedges8 - e8, IDLE_EDGES);
    end
    checks++; if (cg8 !== CG_IDLE) begin failures++; $display("FAIL cg_idle got %b want %b", cg8, CG_IDLE); end
    checks++; if (scan8 !== 1'b0) begin failures++; $display("FAIL cg_scan got %b want 0", scan8); end
  endtask

  task automatic test_width1();
    logic [7:0] res; logic co; int lat, edges;
    logic a, b, c; logic [1:0] exp;
    for (int i = 0; i < 8; i++) begin
      a = i[0]; b = i[1]; c = i[2];
      exp = 2'(a) + 2'(b) + 2'(c);
      run(1'b1, {7'd0, a}, {7'd0, b}, c, res, co, lat, edges);
      checks++;
      if ({co, res[0]} !== exp || lat !== 3 || edges !== 3) begin
        failures++;
        $display("FAIL w1_%0d got cout=%b res=%b lat=%0d edges=%0d want cout=%b res=%b lat=3 edges=3",
                 i, co, res[0], lat, edges, exp[1], exp[0]);
      end
    end
    checks++; if (scan1 !== 1'b0) begin failures++; $display("FAIL w1_scan got %b want 0", scan1); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_clock_gate();
    test_width1();
    checks++;
    if (glitch8 + glitch1 !== 0) begin
      failures++; $display("FAIL cg_change_clk_high got %0d want 0", glitch8 + glitch1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
